// File: rtl/regfile_access_ctrl.sv
// Regfile initiator: fetches rs1/rs2 operands over two read ports and issues writebacks
// over the write port, with x0 handling, RAW stalls against in-flight writes and ack timeouts.
module regfile_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_use_rs1,
  input  logic        dec_use_rs2,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_rs1_data,
  output logic [31:0] op_rs2_data,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [4:0]  rd_addr_a,
  output logic [4:0]  rd_addr_b,
  output logic        rd_addr_a_valid,
  output logic        rd_addr_b_valid,
  input  logic [31:0] rd_data_a,
  input  logic [31:0] rd_data_b,
  input  logic        rd_data_a_ack,
  input  logic        rd_data_b_ack,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        wr_data_valid,
  input  logic        wr_ack,
  output logic        err_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_OUT} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_DRAIN} w_state_t;

  r_state_t      r_state, r_next;
  w_state_t      w_state, w_next;
  logic          need_a, need_b, dec_fire, wb_fire, wb_real, w_busy, hazard;
  logic          r_tick, w_tick;
  logic [CW-1:0] r_cnt, w_cnt;

  assign need_a   = dec_use_rs1 && (dec_rs1 != 5'd0);
  assign need_b   = dec_use_rs2 && (dec_rs2 != 5'd0);
  assign wb_ready = (w_state == W_IDLE) && !wr_ack;
  assign wb_fire  = wb_valid && wb_ready;
  assign wb_real  = wb_fire && (wb_rd != 5'd0);
  // wr_addr is never 0 while busy, since x0 writebacks are dropped at accept
  assign w_busy   = (w_state == W_REQ) || (w_state == W_DRAIN);
  assign hazard   = (need_a && ((w_busy && dec_rs1 == wr_addr) || (wb_real && dec_rs1 == wb_rd))) ||
                    (need_b && ((w_busy && dec_rs2 == wr_addr) || (wb_real && dec_rs2 == wb_rd)));
  assign dec_ready = (r_state == R_IDLE) && !rd_data_a_ack && !rd_data_b_ack && !hazard;
  assign dec_fire  = dec_valid && dec_ready;
  assign op_valid  = (r_state == R_OUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (dec_fire) r_next = (need_a || need_b) ? R_REQ : R_OUT;
      R_REQ:   if ((!rd_addr_a_valid || rd_data_a_ack) && (!rd_addr_b_valid || rd_data_b_ack))
                 r_next = R_OUT;
      R_OUT:   if (op_ready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (wb_real) w_next = W_REQ;
      W_REQ:   if (wr_ack) w_next = W_DRAIN;
      W_DRAIN: if (!wr_ack) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Read port requests and operand capture; a port drops its valid right after its ack
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_a       <= 5'd0;
      rd_addr_b       <= 5'd0;
      rd_addr_a_valid <= 1'b0;
      rd_addr_b_valid <= 1'b0;
      op_rs1_data     <= 32'd0;
      op_rs2_data     <= 32'd0;
    end else if (dec_fire) begin
      rd_addr_a       <= dec_rs1;
      rd_addr_b       <= dec_rs2;
      rd_addr_a_valid <= need_a;
      rd_addr_b_valid <= need_b;
      op_rs1_data     <= 32'd0;
      op_rs2_data     <= 32'd0;
    end else if (r_state == R_REQ) begin
      if (rd_addr_a_valid && rd_data_a_ack) begin
        op_rs1_data     <= rd_data_a;
        rd_addr_a_valid <= 1'b0;
      end
      if (rd_addr_b_valid && rd_data_b_ack) begin
        op_rs2_data     <= rd_data_b;
        rd_addr_b_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr       <= 5'd0;
      wr_data       <= 32'd0;
      wr_data_valid <= 1'b0;
    end else if (w_state == W_IDLE && wb_real) begin
      wr_addr       <= wb_rd;
      wr_data       <= wb_data;
      wr_data_valid <= 1'b1;
    end else if (w_state == W_REQ && wr_ack) begin
      wr_data_valid <= 1'b0;
    end
  end

  // Timeout counters tick only on REQ cycles that end without the request completing
  assign r_tick = (r_state == R_REQ) && (r_next == R_REQ) && (r_cnt != T_MAX);
  assign w_tick = (w_state == W_REQ) && (w_next == W_REQ) && (w_cnt != T_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      w_cnt       <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (r_next != r_state) r_cnt <= '0;
      else if (r_tick)       r_cnt <= r_cnt + 1'b1;
      if (w_next != w_state) w_cnt <= '0;
      else if (w_tick)       w_cnt <= w_cnt + 1'b1;
      if ((r_tick && r_cnt == T_MAX - 1'b1) || (w_tick && w_cnt == T_MAX - 1'b1))
        err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: directed latency/hazard/timeout scenarios plus a randomized
// run scored against an architectural register-file model with a FIFO of expected operands.
module tb_regfile_access_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid, dec_ready, dec_use_rs1, dec_use_rs2;
  logic [4:0]  dec_rs1, dec_rs2;
  logic        op_valid, op_ready;
  logic [31:0] op_rs1_data, op_rs2_data;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic        rd_addr_a_valid, rd_addr_b_valid;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_data_a_ack, rd_data_b_ack;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_data_valid, wr_ack, err_timeout;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] init_val [32];
  logic [31:0] mem [32];
  logic [31:0] ref_regs [32];
  logic        ack_en = 1'b1;
  logic        jitter = 1'b0;
  logic        wait_a, wait_b;

  regfile_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .op_valid(op_valid), .op_ready(op_ready), .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_addr_a_valid(rd_addr_a_valid), .rd_addr_b_valid(rd_addr_b_valid),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_data_a_ack(rd_data_a_ack), .rd_data_b_ack(rd_data_b_ack),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_ack(wr_ack),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Regfile: registered single-cycle acks, optional one-cycle jitter on reads
  always @(posedge clk) begin
    if (reset) begin
      rd_data_a_ack <= 1'b0; rd_data_b_ack <= 1'b0; wr_ack <= 1'b0;
      rd_data_a <= 32'd0; rd_data_b <= 32'd0; wait_a <= 1'b0; wait_b <= 1'b0;
      for (int i = 0; i < 32; i++) mem[i] <= init_val[i];
    end else begin
      rd_data_a_ack <= 1'b0; rd_data_b_ack <= 1'b0; wr_ack <= 1'b0;
      if (rd_addr_a_valid && !rd_data_a_ack && ack_en) begin
        if (jitter && !wait_a && $urandom_range(0, 1) == 1) wait_a <= 1'b1;
        else begin wait_a <= 1'b0; rd_data_a_ack <= 1'b1; rd_data_a <= mem[rd_addr_a]; end
      end
      if (rd_addr_b_valid && !rd_data_b_ack && ack_en) begin
        if (jitter && !wait_b && $urandom_range(0, 1) == 1) wait_b <= 1'b1;
        else begin wait_b <= 1'b0; rd_data_b_ack <= 1'b1; rd_data_b <= mem[rd_addr_b]; end
      end
      if (wr_data_valid && !wr_ack && ack_en) begin
        wr_ack <= 1'b1; mem[wr_addr] <= wr_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_use_rs1 = 0; dec_use_rs2 = 0;
    op_ready = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic do_read(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
                         output logic [31:0] d1, output logic [31:0] d2, output bit ok);
    ok = 0; d1 = 0; d2 = 0;
    dec_valid = 1; dec_rs1 = r1; dec_rs2 = r2; dec_use_rs1 = u1; dec_use_rs2 = u2;
    #1;
    for (int i = 0; i < 20 && !dec_ready; i++) begin @(posedge clk); #2; end
    if (dec_ready) begin
      @(posedge clk); #1;
      dec_valid = 0; op_ready = 1;
      for (int i = 0; i < 20; i++) begin
        if (op_valid) begin d1 = op_rs1_data; d2 = op_rs2_data; ok = 1; break; end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      op_ready = 0;
    end else begin
      dec_valid = 0; @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    for (int i = 0; i < 32; i++) init_val[i] = $urandom;
    init_val[1] = 32'd5; init_val[2] = 32'd7;
    for (int i = 0; i < 32; i++) ref_regs[i] = init_val[i];
    repeat (2) tick();
    n_checks++;
    if ({op_valid, rd_addr_a_valid, rd_addr_b_valid, wr_data_valid, err_timeout} !== 5'b0)
      $display("FAIL reset_valids: got %b want 00000",
               {op_valid, rd_addr_a_valid, rd_addr_b_valid, wr_data_valid, err_timeout});
    else n_pass++;
    n_checks++;
    if ({op_rs1_data, op_rs2_data, rd_addr_a, rd_addr_b, wr_addr, wr_data} !== '0)
      $display("FAIL reset_data: op %h %h addr %0d %0d wr %0d %h want all 0",
               op_rs1_data, op_rs2_data, rd_addr_a, rd_addr_b, wr_addr, wr_data);
    else n_pass++;
    reset = 0;
    tick();
    n_checks++;
    if ({dec_ready, wb_ready} !== 2'b11)
      $display("FAIL reset_ready: got %b want 11", {dec_ready, wb_ready});
    else n_pass++;
  endtask

  task automatic test_both_operands();
    dec_valid = 1; dec_rs1 = 1; dec_rs2 = 2; dec_use_rs1 = 1; dec_use_rs2 = 1;
    #1;
    n_checks++;
    if (dec_ready !== 1'b1) $display("FAIL t1_accept: dec_ready %b want 1", dec_ready);
    else n_pass++;
    @(posedge clk); #1;
    dec_valid = 0;
    n_checks++;
    if ({rd_addr_a_valid, rd_addr_b_valid, rd_addr_a, rd_addr_b, op_valid} !== {2'b11, 5'd1, 5'd2, 1'b0})
      $display("FAIL t1_cyc1: va %b vb %b a %0d b %0d op %b want 1 1 1 2 0",
               rd_addr_a_valid, rd_addr_b_valid, rd_addr_a, rd_addr_b, op_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (op_valid !== 1'b0) $display("FAIL t1_cyc2: op_valid %b want 0", op_valid);
    else n_pass++;
    tick();
    n_checks++;
    if ({op_valid, rd_addr_a_valid, rd_addr_b_valid} !== 3'b100 ||
        op_rs1_data !== ref_regs[1] || op_rs2_data !== ref_regs[2])
      $display("FAIL t1_cyc3: op %b va %b vb %b data %0d %0d want 1 0 0 %0d %0d", op_valid,
               rd_addr_a_valid, rd_addr_b_valid, op_rs1_data, op_rs2_data, ref_regs[1], ref_regs[2]);
    else n_pass++;
    op_ready = 1;
    tick();
    op_ready = 0;
    n_checks++;
    if ({op_valid, dec_ready} !== 2'b01)
      $display("FAIL t1_cyc4: op_valid %b dec_ready %b want 0 1", op_valid, dec_ready);
    else n_pass++;
  endtask

  task automatic test_x0_unused();
    dec_valid = 1; dec_rs1 = 0; dec_rs2 = 9; dec_use_rs1 = 1; dec_use_rs2 = 0;
    @(posedge clk); #1;
    dec_valid = 0;
    n_checks++;
    if ({op_valid, rd_addr_a_valid, rd_addr_b_valid} !== 3'b100 || {op_rs1_data, op_rs2_data} !== 64'd0)
      $display("FAIL t2_cyc1: op %b va %b vb %b data %h %h want 1 0 0 0 0",
               op_valid, rd_addr_a_valid, rd_addr_b_valid, op_rs1_data, op_rs2_data);
    else n_pass++;
    op_ready = 1;
    tick();
    op_ready = 0;
    n_checks++;
    if (op_valid !== 1'b0) $display("FAIL t2_release: op_valid %b want 0", op_valid);
    else n_pass++;
  endtask

  task automatic test_writeback();
    logic [31:0] d1, d2;
    bit ok;
    wb_valid = 1; wb_rd = 3; wb_data = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (wb_ready !== 1'b1) $display("FAIL t3_accept: wb_ready %b want 1", wb_ready);
    else n_pass++;
    @(posedge clk); #1;
    wb_valid = 0; ref_regs[3] = 32'hDEADBEEF;
    n_checks++;
    if ({wr_data_valid, wr_addr, wr_data} !== {1'b1, 5'd3, 32'hDEADBEEF})
      $display("FAIL t3_cyc1: v %b addr %0d data %h want 1 3 deadbeef", wr_data_valid, wr_addr, wr_data);
    else n_pass++;
    tick();
    n_checks++;
    if ({wr_data_valid, wb_ready} !== 2'b10)
      $display("FAIL t3_cyc2: v %b wb_ready %b want 1 0", wr_data_valid, wb_ready);
    else n_pass++;
    tick();
    n_checks++;
    if ({wr_data_valid, wb_ready} !== 2'b00)
      $display("FAIL t3_cyc3: v %b wb_ready %b want 0 0", wr_data_valid, wb_ready);
    else n_pass++;
    tick();
    n_checks++;
    if ({wr_data_valid, wb_ready} !== 2'b01)
      $display("FAIL t3_cyc4: v %b wb_ready %b want 0 1", wr_data_valid, wb_ready);
    else n_pass++;
    do_read(5'd3, 5'd0, 1'b1, 1'b1, d1, d2, ok);
    n_checks++;
    if (!ok || d1 !== ref_regs[3] || d2 !== 32'd0)
      $display("FAIL t3_readback: ok %0d data %h %h want 1 %h 0", ok, d1, d2, ref_regs[3]);
    else n_pass++;
  endtask

  task automatic test_wb_x0();
    logic seen;
    seen = 0;
    wb_valid = 1; wb_rd = 0; wb_data = $urandom;
    #1;
    n_checks++;
    if (wb_ready !== 1'b1) $display("FAIL t4_accept: wb_ready %b want 1", wb_ready);
    else n_pass++;
    @(posedge clk); #1;
    wb_valid = 0;
    n_checks++;
    if (wb_ready !== 1'b1) $display("FAIL t4_ready_next: wb_ready %b want 1", wb_ready);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin seen = seen | wr_data_valid; tick(); end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL t4_no_write: wr_data_valid seen %b want 0", seen);
    else n_pass++;
  endtask

  task automatic test_raw_hazard();
    logic [31:0] d;
    int k;
    bit ok;
    d = $urandom;
    wb_valid = 1; wb_rd = 4; wb_data = d;
    dec_valid = 1; dec_rs1 = 4; dec_use_rs1 = 1; dec_rs2 = 0; dec_use_rs2 = 0;
    #1;
    n_checks++;
    if ({dec_ready, wb_ready} !== 2'b01)
      $display("FAIL t5_same_cycle: dec_ready %b wb_ready %b want 0 1", dec_ready, wb_ready);
    else n_pass++;
    @(posedge clk); #1;
    wb_valid = 0; ref_regs[4] = d;
    #1;
    k = 1;
    while (!dec_ready && k < 12) begin @(posedge clk); #2; k++; end
    n_checks++;
    if (k !== 4) $display("FAIL t5_stall_len: dec_ready rose at cycle %0d want 4", k);
    else n_pass++;
    @(posedge clk); #1;
    dec_valid = 0; op_ready = 1; ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (op_valid) begin ok = 1; break; end
      tick();
    end
    n_checks++;
    if (!ok || op_rs1_data !== d)
      $display("FAIL t5_operand: ok %0d rs1 %h want 1 %h", ok, op_rs1_data, d);
    else n_pass++;
    tick();
    op_ready = 0;
  endtask

  task automatic test_random();
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [31:0] e1, e2;
    logic        busy, bu1, bu2, n1, n2;
    logic [4:0]  b1, b2;
    int          ops;
    busy = 0; bu1 = 0; bu2 = 0; b1 = 0; b2 = 0; ops = 0;
    jitter = 1;
    for (int c = 0; c < 440; c++) begin
      if (c < 400) begin
        dec_valid = ($urandom_range(0, 2) != 0);
        dec_rs1 = 5'($urandom_range(0, 7)); dec_rs2 = 5'($urandom_range(0, 7));
        dec_use_rs1 = ($urandom_range(0, 3) != 0); dec_use_rs2 = ($urandom_range(0, 3) != 0);
        wb_valid = ($urandom_range(0, 2) == 0);
        wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
        if (busy && ((bu1 && wb_rd == b1) || (bu2 && wb_rd == b2))) wb_valid = 0;
        op_ready = ($urandom_range(0, 1) == 1);
      end else begin
        idle_inputs(); op_ready = 1;
      end
      #1;
      if (op_valid && op_ready) begin
        n_checks++;
        if (q1.size() == 0) $display("FAIL rand_unexpected_op: data %h %h with no pending read",
                                     op_rs1_data, op_rs2_data);
        else begin
          e1 = q1.pop_front(); e2 = q2.pop_front();
          if (op_rs1_data !== e1 || op_rs2_data !== e2)
            $display("FAIL rand_operands: got %h %h want %h %h", op_rs1_data, op_rs2_data, e1, e2);
          else n_pass++;
        end
        busy = 0; ops++;
      end
      if (dec_valid && dec_ready) begin
        n1 = dec_use_rs1 && dec_rs1 != 0; n2 = dec_use_rs2 && dec_rs2 != 0;
        q1.push_back(n1 ? ref_regs[dec_rs1] : 32'd0);
        q2.push_back(n2 ? ref_regs[dec_rs2] : 32'd0);
        busy = 1; bu1 = n1; bu2 = n2; b1 = dec_rs1; b2 = dec_rs2;
      end
      if (wb_valid && wb_ready && wb_rd != 0) ref_regs[wb_rd] = wb_data;
      @(posedge clk); #1;
    end
    jitter = 0;
    n_checks++;
    if (q1.size() != 0 || ops < 20 || err_timeout !== 1'b0)
      $display("FAIL rand_drain: pending %0d ops %0d err %b want 0 >=20 0", q1.size(), ops, err_timeout);
    else n_pass++;
  endtask

  task automatic test_timeout();
    ack_en = 0;
    dec_valid = 1; dec_rs1 = 5; dec_rs2 = 6; dec_use_rs1 = 1; dec_use_rs2 = 1;
    wb_valid = 1; wb_rd = 9; wb_data = $urandom;
    #1;
    n_checks++;
    if ({dec_ready, wb_ready} !== 2'b11)
      $display("FAIL t6_accept: dec_ready %b wb_ready %b want 1 1", dec_ready, wb_ready);
    else n_pass++;
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) tick();
    n_checks++;
    if (err_timeout !== 1'b0) $display("FAIL t6_early: err_timeout %b after 3 REQ cycles want 0", err_timeout);
    else n_pass++;
    tick();
    n_checks++;
    if (err_timeout !== 1'b1) $display("FAIL t6_fire: err_timeout %b after 4 REQ cycles want 1", err_timeout);
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if ({err_timeout, rd_addr_a_valid, rd_addr_b_valid, wr_data_valid, op_valid} !== 5'b11110)
      $display("FAIL t6_hold: err va vb wv op = %b want 11110",
               {err_timeout, rd_addr_a_valid, rd_addr_b_valid, wr_data_valid, op_valid});
    else n_pass++;
    reset = 1;
    tick();
    n_checks++;
    if ({err_timeout, rd_addr_a_valid, rd_addr_b_valid, wr_data_valid, op_valid} !== 5'b00000)
      $display("FAIL t6_reset: err va vb wv op = %b want 00000",
               {err_timeout, rd_addr_a_valid, rd_addr_b_valid, wr_data_valid, op_valid});
    else n_pass++;
    reset = 0; ack_en = 1;
    tick();
    n_checks++;
    if ({dec_ready, wb_ready, err_timeout} !== 3'b110)
      $display("FAIL t6_after_reset: dec_ready wb_ready err = %b want 110", {dec_ready, wb_ready, err_timeout});
    else n_pass++;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_both_operands();
    test_x0_unused();
    test_writeback();
    test_wb_x0();
    test_raw_hazard();
    test_random();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
